// File: rtl/pisa_pkg.sv
// Shared definitions for the fetch front end: state encoding and instruction-word field positions.
package pisa_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetchOp  = 3'd1,
    StFetchImm = 3'd2,
    StIssue    = 3'd3,
    StHalted   = 3'd4
  } fetch_state_t;

  localparam int unsigned OPCODE_MSB   = 15;
  localparam int unsigned OPCODE_LSB   = 8;
  // Bit position within the opcode byte, not within the memory word.
  localparam int unsigned IMM_FLAG_BIT = 5;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with +1 / +2 sequential advance and redirect load.
module fetch_pc #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance_i,
  input  logic              two_word_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Redirect wins over sequential advance; sums wrap modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (advance_i) begin
      pc_d = pc_q + (two_word_i ? ADDR_W'(2) : ADDR_W'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: req/ack memory reads, optional immediate word, issue handshake.
// Optional FETCH_BUS_ERR_EN adds mem_err_i / fault_o for bus-error halting.
module fetch_unit
  import pisa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef FETCH_BUS_ERR_EN
  input  logic              mem_err_i,
  output logic              fault_o,
`endif
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        opcode_o,
  output logic [7:0]        operands_o,
  output logic [DATA_W-1:0] immediate_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic              halted_o
);

  fetch_state_t      state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        operands_q, operands_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] pc;
  logic              ack_ok, ack_err, issue_hs, pc_adv, pc_redir;

  assign mem_req_o = (state_q == StFetchOp) || (state_q == StFetchImm);

`ifdef FETCH_BUS_ERR_EN
  logic fault_q;
  assign ack_err = mem_req_o && mem_ack_i && mem_err_i;
`else
  assign ack_err = 1'b0;
`endif

  assign ack_ok   = mem_req_o && mem_ack_i && !ack_err;
  assign issue_hs = (state_q == StIssue) && instr_ready_i;
  assign pc_redir = issue_hs && !halt_i && redirect_valid_i;
  assign pc_adv   = issue_hs && !halt_i && !redirect_valid_i;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    operands_d = operands_q;
    imm_d      = imm_q;
    case (state_q)
      StIdle: state_d = StFetchOp;
      StFetchOp: begin
        if (ack_err) begin
          state_d = StHalted;
        end else if (ack_ok) begin
          opcode_d   = mem_rdata_i[OPCODE_MSB:OPCODE_LSB];
          operands_d = mem_rdata_i[OPCODE_LSB-1:0];
          if (mem_rdata_i[OPCODE_LSB+IMM_FLAG_BIT]) begin
            state_d = StFetchImm;
          end else begin
            imm_d   = '0;
            state_d = StIssue;
          end
        end
      end
      StFetchImm: begin
        if (ack_err) begin
          state_d = StHalted;
        end else if (ack_ok) begin
          imm_d   = mem_rdata_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue_hs) begin
          state_d = halt_i ? StHalted : StFetchOp;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      opcode_q   <= 8'h00;
      operands_q <= 8'h00;
      imm_q      <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operands_q <= operands_d;
      imm_q      <= imm_d;
    end
  end

`ifdef FETCH_BUS_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
    end else if (ack_err) begin
      fault_q <= 1'b1;
    end
  end
  assign fault_o = fault_q;
`endif

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .advance_i  (pc_adv),
    .two_word_i (opcode_q[IMM_FLAG_BIT]),
    .redirect_i (pc_redir),
    .target_i   (redirect_target_i),
    .pc_o       (pc)
  );

  // The immediate lives in the word after the opcode, wrapping at the top of memory.
  assign mem_addr_o    = (state_q == StFetchImm) ? pc + ADDR_W'(1) : pc;
  assign instr_valid_o = (state_q == StIssue);
  assign halted_o      = (state_q == StHalted);
  assign opcode_o      = opcode_q;
  assign operands_o    = operands_q;
  assign immediate_o   = imm_q;
  assign pc_o          = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of instructions issued in sequence plus reset/abort sequences.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] word;
    logic [15:0] imm;
    int          stall;
    int          ack_dly;
    logic        halt;
    logic        redir;
    logic [15:0] target;
    logic [15:0] exp_pc;
    logic [7:0]  exp_op;
    logic [7:0]  exp_opr;
    logic [15:0] exp_imm;
    logic [15:0] exp_next;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [7:0]  operands;
  logic [15:0] immediate;
  logic [15:0] pc;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halted;

  logic [15:0] mem [0:65535];
  int          wait_cnt;
  int          ack_dly;
  logic        manual;
  logic        man_ack;
  logic [15:0] man_data;

  int passed;
  int total;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mem_req_o         (mem_req),
    .mem_addr_o        (mem_addr),
    .mem_ack_i         (mem_ack),
    .mem_rdata_i       (mem_rdata),
    .instr_valid_o     (instr_valid),
    .instr_ready_i     (instr_ready),
    .opcode_o          (opcode),
    .operands_o        (operands),
    .immediate_o       (immediate),
    .pc_o              (pc),
    .halt_i            (halt),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .halted_o          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after ack_dly wait cycles, or driven by hand when manual is set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign mem_ack   = manual ? man_ack : (mem_req && (wait_cnt >= ack_dly));
  assign mem_rdata = manual ? man_data : mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_reset_state();
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_opcode", {24'd0, opcode}, 0);
    check("rst_operands", {24'd0, operands}, 0);
    check("rst_immediate", {16'd0, immediate}, 0);
    check("rst_pc", {16'd0, pc}, 0);
    check("rst_halted", {31'd0, halted}, 0);
  endtask

  task automatic issue_one(input vec_t v);
    int n;
    ack_dly = v.ack_dly;
    n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("instr_valid", {31'd0, instr_valid}, 1);
    check("opcode", {24'd0, opcode}, {24'd0, v.exp_op});
    check("operands", {24'd0, operands}, {24'd0, v.exp_opr});
    check("immediate", {16'd0, immediate}, {16'd0, v.exp_imm});
    check("pc", {16'd0, pc}, {16'd0, v.exp_pc});
    halt            = v.halt;
    redirect_valid  = v.redir;
    redirect_target = v.target;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 1);
      check("stall_mem_req", {31'd0, mem_req}, 0);
      check("stall_opcode", {24'd0, opcode}, {24'd0, v.exp_op});
      check("stall_immediate", {16'd0, immediate}, {16'd0, v.exp_imm});
      check("stall_pc", {16'd0, pc}, {16'd0, v.exp_pc});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready    = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    if (v.halt) begin
      check("halted", {31'd0, halted}, 1);
      check("halt_mem_req", {31'd0, mem_req}, 0);
      check("halt_valid", {31'd0, instr_valid}, 0);
    end else begin
      check("next_mem_req", {31'd0, mem_req}, 1);
      check("next_mem_addr", {16'd0, mem_addr}, {16'd0, v.exp_next});
      check("next_valid", {31'd0, instr_valid}, 0);
    end
  endtask

  vec_t tbl [7];
  vec_t wrap_a, wrap_b, to_top;

  initial begin
    logic [15:0] a;
    int          busy;
    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0000;
    manual = 1'b0;
    man_ack = 1'b0;
    man_data = 16'h0000;
    ack_dly = 0;

    //          word     imm      stl dly halt redir target   pc      op     opr    imm      next
    tbl[0] = '{16'h8012, 16'h0000, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h80, 8'h12, 16'h0000, 16'h0001};
    tbl[1] = '{16'hA003, 16'h0005, 0, 1, 1'b0, 1'b0, 16'h0000, 16'h0001, 8'hA0, 8'h03, 16'h0005, 16'h0003};
    tbl[2] = '{16'h2000, 16'h0040, 0, 0, 1'b0, 1'b1, 16'h0040, 16'h0003, 8'h20, 8'h00, 16'h0040, 16'h0040};
    tbl[3] = '{16'h0155, 16'h0000, 3, 2, 1'b0, 1'b0, 16'h0000, 16'h0040, 8'h01, 8'h55, 16'h0000, 16'h0041};
    tbl[4] = '{16'h1234, 16'h0000, 0, 0, 1'b0, 1'b1, 16'h0100, 16'h0041, 8'h12, 8'h34, 16'h0000, 16'h0100};
    tbl[5] = '{16'hE0FF, 16'hBEEF, 1, 0, 1'b0, 1'b0, 16'h0000, 16'h0100, 8'hE0, 8'hFF, 16'hBEEF, 16'h0102};
    tbl[6] = '{16'h0300, 16'h0000, 0, 0, 1'b1, 1'b1, 16'h0200, 16'h0102, 8'h03, 8'h00, 16'h0000, 16'h0000};
    wrap_a = '{16'h8012, 16'h0000, 0, 0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h80, 8'h12, 16'h0000, 16'hFFFF};
    wrap_b = '{16'hA107, 16'h8012, 0, 1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 8'hA1, 8'h07, 16'h8012, 16'h0001};
    to_top = '{16'hA003, 16'h0005, 0, 0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 8'hA0, 8'h03, 16'h0005, 16'hFFFF};

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      a = tbl[i].exp_pc;
      mem[a] = tbl[i].word;
      if (tbl[i].word[13]) begin
        a = a + 16'd1;
        mem[a] = tbl[i].imm;
      end
    end
    mem[16'hFFFF] = 16'hA107;

    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) issue_one(tbl[i]);

    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || instr_valid || !halted) busy++;
    end
    check("halt_quiet_20", busy, 0);

    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_mem_req", {31'd0, mem_req}, 1);
    check("restart_mem_addr", {16'd0, mem_addr}, 32'h0000);

    // Wrap: opcode at 0xFFFF takes its immediate from 0x0000, then continues at 0x0001.
    issue_one(wrap_a);
    issue_one(wrap_b);
    issue_one(to_top);

    // Abort the immediate fetch at 0x0000 with reset, then deliver a stale ack in IDLE.
    ack_dly = 0;
    @(negedge clk);
    manual  = 1'b1;
    man_ack = 1'b0;
    check("imm_req", {31'd0, mem_req}, 1);
    check("imm_addr_wrap", {16'd0, mem_addr}, 32'h0000);
    @(negedge clk);
    check("imm_req_held", {31'd0, mem_req}, 1);
    check("imm_addr_held", {16'd0, mem_addr}, 32'h0000);
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", {31'd0, mem_req}, 0);
    check("abort_pc", {16'd0, pc}, 32'h0000);
    @(negedge clk);
    rst_n    = 1'b1;
    man_ack  = 1'b1;
    man_data = 16'hFFFF;
    @(negedge clk);
    man_ack = 1'b0;
    manual  = 1'b0;
    check("late_ack_req", {31'd0, mem_req}, 1);
    check("late_ack_addr", {16'd0, mem_addr}, 32'h0000);
    check("late_ack_opcode", {24'd0, opcode}, 0);
    check("late_ack_imm", {16'd0, immediate}, 0);
    issue_one(tbl[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: reads instruction words from memory over a req/ack handshake and presents opcode, operand byte and optional immediate to the control unit and datapath. Owns the program counter and applies jump redirects and halts reported back at issue. Produces the `opcode` the control unit decodes; consumes its `halt` and jump outcome.

## Interface
- `ADDR_W`, 16, word address width.
- `DATA_W`, 16, memory word width; instruction word is `[15:8]` opcode and `[7:0]` operand fields.
- `RESET_PC`, 0, first fetch address after reset.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_req` out 1: memory read request.
- `mem_addr` out `ADDR_W`: read word address.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in `DATA_W`: read data.
- `instr_valid` out 1: instruction presented.
- `instr_ready` in 1: consumer accepts the instruction.
- `opcode` out 8: instruction opcode.
- `operands` out 8: register fields.
- `immediate` out `DATA_W`: second word; 0 when the instruction has none.
- `pc` out `ADDR_W`: address of the presented instruction.
- `halt` in 1: decoded halt or invalid opcode for the presented instruction.
- `redirect_valid` in 1: taken jump for the presented instruction.
- `redirect_target` in `ADDR_W`: jump target.
- `halted` out 1: fetch stopped.

## Operation
- States: IDLE, FETCH_OP, FETCH_IMM, ISSUE, HALTED.
- IDLE: entered on reset; moves to FETCH_OP on the first clock edge after `rst` rises.
- FETCH_OP: `mem_req`=1, `mem_addr`=`pc`. On `mem_req&&mem_ack`, capture `mem_rdata[15:8]`→`opcode` and `[7:0]`→`operands`.
  - If `mem_rdata[13]` (opcode bit 5, immediate flag) is set, go to FETCH_IMM.
  - Otherwise clear `immediate` and go to ISSUE.
- FETCH_IMM: `mem_req`=1, `mem_addr`=`pc+1`. On ack, capture `immediate` and go to ISSUE.
- ISSUE: `instr_valid`=1 and `mem_req`=0. Outputs stay stable until `instr_valid&&instr_ready`. At that handshake:
  - If `halt`=1, go to HALTED; `pc` is unchanged.
  - Else if `redirect_valid`=1, set `pc` to `redirect_target` and go to FETCH_OP.
  - Else set `pc` to `pc+1`, or `pc+2` if the instruction had an immediate, and go to FETCH_OP.
- `halt` and redirect inputs are ignored outside the issue handshake. `halt` has priority over redirect.
- HALTED: `halted`=1; `mem_req` and `instr_valid` are 0; exit only by reset.
- Address arithmetic is modulo 2^`ADDR_W`. Example: a fetch at 0xFFFF with an immediate reads the immediate at 0x0000, then next `pc` is 0x0001.
- Memory handshake: once `mem_req` is raised, it and `mem_addr` hold until ack. The request is never withdrawn except by reset.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `mem_req`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `opcode`=0x00 (nop), `operands`=0, `immediate`=0, `halted`=0.
- `mem_ack` may assert in the same cycle as `mem_req` (zero wait) or any later cycle. Data is captured on the edge where `mem_req&&mem_ack`.
- Zero-wait latency, FETCH_OP entry to `instr_valid`: 1 cycle without an immediate, 2 cycles with one. Peak throughput is one instruction per 2 cycles (3 with an immediate).
- A redirect accepted at the handshake drives `mem_addr`=`redirect_target` in the very next cycle.
- Reset asserted mid-fetch clears `mem_req` asynchronously. Memory must tolerate the aborted request, and its late ack is ignored in IDLE.

## Configuration
- `FETCH_BUS_ERR_EN` defined: adds input `mem_err` (valid with `mem_ack`) and output `fault`.
  - An ack with `mem_err`=1 in FETCH_OP or FETCH_IMM goes to HALTED with `fault`=1 and `instr_valid` never raised.
  - `fault` resets to 0 and is sticky until reset.
- Undefined: neither port exists and every ack is treated as good data.

## Structure
- Shared package `pisa_pkg`:
  - fetch state enum `fetch_state_t`;
  - constants `OPCODE_MSB`=15, `OPCODE_LSB`=8, `IMM_FLAG_BIT`=5 (bit position within the opcode).
- One sub-module, `fetch_pc`: holds the PC register and computes next-PC (+1, +2, redirect) with reset to `RESET_PC`. FSM and capture registers stay in `fetch_unit`.

## Test plan
- Zero-wait memory, addr 0 = 0x8012, `instr_ready`=1 → `opcode`=0x80, `operands`=0x12, `immediate`=0, `pc`=0, then next `mem_addr`=0x0001.
- Addr 0 = 0xA003, addr 1 = 0x0005 → one `instr_valid` with `immediate`=0x0005; next fetch at 0x0002.
- Backpressure: `instr_ready`=0 for 3 cycles in ISSUE → outputs unchanged and `mem_req`=0 throughout; accepted on the 4th cycle.
- Jump: 0x2000 / 0x0040 issued with `redirect_valid`=1, target 0x0040 → next cycle `mem_addr`=0x0040, `mem_req`=1.
- Halt: opcode 0x03 with `halt`=1 at handshake → `halted`=1 and no `mem_req` for 20 cycles; reset restarts fetch at `RESET_PC`.
- `rst` low during FETCH_IMM with an ack 2 cycles late → `mem_req` drops immediately, the late ack is ignored, and fetch restarts at `RESET_PC`. Also run with `pc` at 0xFFFF to check wrap to 0x0000.
